// File: rtl/cdb_arbiter_if.sv
// Result-producer handshakes (ALU, LSB) and the registered CDB broadcast.
// master = producers/consumers side, slave = cdb_arbiter.
interface cdb_arbiter_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_value;
  logic              alu_ready;
  logic              lsb_valid;
  logic [TAG_W-1:0]  lsb_tag;
  logic [DATA_W-1:0] lsb_value;
  logic              lsb_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_src;

  modport master (
    output alu_valid, alu_tag, alu_value, lsb_valid, lsb_tag, lsb_value,
    input  alu_ready, lsb_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
  );
  modport slave (
    input  alu_valid, alu_tag, alu_value, lsb_valid, lsb_tag, lsb_value,
    output alu_ready, lsb_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two 2-entry result FIFOs (ALU, LSB) feeding a round-robin
// pick that drives the registered common data bus.
module cdb_fifo #(
  parameter int W = 37
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         ready,
  output logic         nonempty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  logic         push;

  assign ready    = rdy_in && (cnt < 2'd2);
  // A flush cycle must not capture a new result even though ready is high.
  assign push     = push_valid && ready && !clear;
  assign nonempty = (cnt != 2'd0);
  assign head     = mem[rp];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (rdy_in) begin
      if (clear) begin
        wp  <= 1'b0;
        rp  <= 1'b0;
        cnt <= 2'd0;
      end else begin
        if (push) wp <= ~wp;
        if (pop)  rp <= ~rp;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk_in)
    if (push) mem[wp] <= push_data;
endmodule

module cdb_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear,
  cdb_arbiter_if.slave  bus
);
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } res_t;

  res_t [1:0] in_res, head;
  logic [1:0] in_vld, in_rdy, ne, pop;
  logic       gnt, gsrc, rr_last;

  logic              cdb_valid_q, cdb_src_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_value_q;

  // index 0 = ALU, 1 = LSB throughout
  assign in_vld = {bus.lsb_valid, bus.alu_valid};
  assign in_res = {res_t'({bus.lsb_tag, bus.lsb_value}),
                   res_t'({bus.alu_tag, bus.alu_value})};
  assign bus.alu_ready = in_rdy[0];
  assign bus.lsb_ready = in_rdy[1];

  for (genvar i = 0; i < 2; i++) begin : g_src
    cdb_fifo #(.W($bits(res_t))) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .clear      (clear),
      .push_valid (in_vld[i]),
      .push_data  (in_res[i]),
      .pop        (pop[i]),
      .ready      (in_rdy[i]),
      .nonempty   (ne[i]),
      .head       (head[i])
    );
    assign pop[i] = rdy_in && !clear && gnt && (gsrc == 1'(i));
  end

  // Under contention the source that did not win last time goes first.
  always_comb begin
    gnt  = 1'b0;
    gsrc = 1'b0;
    if (ne[0] && ne[1]) begin
      gnt  = 1'b1;
      gsrc = ~rr_last;
    end else if (ne[0]) begin
      gnt  = 1'b1;
      gsrc = 1'b0;
    end else if (ne[1]) begin
      gnt  = 1'b1;
      gsrc = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= 1'b0;
      rr_last     <= 1'b1;
    end else if (rdy_in) begin
      if (clear) begin
        cdb_valid_q <= 1'b0;
        cdb_tag_q   <= '0;
        cdb_value_q <= '0;
        cdb_src_q   <= 1'b0;
        rr_last     <= 1'b1;
      end else begin
        cdb_valid_q <= gnt;
        if (gnt) begin
          cdb_tag_q   <= head[gsrc].tag;
          cdb_value_q <= head[gsrc].value;
          cdb_src_q   <= gsrc;
          rr_last     <= gsrc;
        end
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule
